// File: rtl/gate_sweep_ctrl.sv
// Truth-table sweeper for a 2-input gate: drives all four input vectors in order,
// captures the gate output for each and compares the table against an expected value.
module gate_sweep_ctrl #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] expected,
    output logic       gate_a,
    output logic       gate_b,
    input  logic       gate_y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] result
);

    localparam logic [3:0] LastCnt = 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StSample,
        StDone
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] result_d;
    logic       pass_d;
    logic       busy_d;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        result_d = result;
        pass_d   = pass;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StDrive;
                    idx_d    = 2'd0;
                    cnt_d    = 4'd0;
                    result_d = 4'd0;
                    pass_d   = 1'b0;
                end
            end
            StDrive: begin
                if (abort) begin
                    state_d = StIdle;
                    pass_d  = 1'b0;
                end else if (cnt_q == LastCnt) begin
                    state_d = StSample;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StSample: begin
                // The sample is taken even on abort so partial results stay visible.
                result_d[idx_q] = gate_y;
                if (abort) begin
                    state_d = StIdle;
                    pass_d  = 1'b0;
                end else if (idx_q == 2'd3) begin
                    state_d = StDone;
                    // Compared here so pass is already valid while done is high.
                    pass_d  = (result_d == expected);
                end else begin
                    state_d = StDrive;
                    idx_d   = idx_q + 2'd1;
                    cnt_d   = 4'd0;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        busy_d = (state_d == StDrive) || (state_d == StSample);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= 2'd0;
            cnt_q   <= 4'd0;
            result  <= 4'd0;
            pass    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            gate_a  <= 1'b0;
            gate_b  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= busy_d ? idx_d : 2'd0;
            cnt_q   <= busy_d ? cnt_d : 4'd0;
            result  <= result_d;
            pass    <= pass_d;
            busy    <= busy_d;
            done    <= (state_d == StDone);
            gate_a  <= busy_d & idx_d[1];
            gate_b  <= busy_d & idx_d[0];
        end
    end

endmodule

// File: doc/gate_sweep_ctrl.md
GATE_SWEEP_CTRL -- requirements
Module: gate_sweep_ctrl

Interface
REQ-001 SHALL have parameter: SETTLE, default 2, cycles each input vector is held before the output is sampled (legal 1..15).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: start  input  1  request a truth-table sweep, sampled in IDLE only.
REQ-005 SHALL have port: abort  input  1  cancel a sweep in progress.
REQ-006 SHALL have port: expected  input  4  expected truth table, bit index = {gate_a,gate_b}.
REQ-007 SHALL have port: gate_a  output  1  first input driven to the 2-input gate under test.
REQ-008 SHALL have port: gate_b  output  1  second input driven to the gate under test.
REQ-009 SHALL have port: gate_y  input  1  output of the gate under test.
REQ-010 SHALL have port: busy  output  1  high while a sweep is in progress (DRIVE or SAMPLE).
REQ-011 SHALL have port: done  output  1  one-cycle pulse on sweep completion.
REQ-012 SHALL have port: pass  output  1  result equals expected, valid from done until next accepted start.
REQ-013 SHALL have port: result  output  4  captured truth table, bit index = {gate_a,gate_b}.

Function
REQ-014 SHALL implement FSM states IDLE, DRIVE, SAMPLE, DONE; all outputs registered.
REQ-015 SHALL, in IDLE with start=1 on an edge, enter DRIVE with vector index idx=0, settle counter=0, result cleared to 0, pass cleared to 0.
REQ-016 SHALL drive gate_a=idx[1], gate_b=idx[0] in DRIVE and SAMPLE; gate_a=gate_b=0 in IDLE and DONE.
REQ-017 SHALL remain in DRIVE exactly SETTLE cycles, then enter SAMPLE.
REQ-018 SHALL, in SAMPLE (one cycle), write gate_y into result[idx]; if idx==3 enter DONE, else increment idx, clear settle counter, return to DRIVE.
REQ-019 SHALL visit vectors in order 00, 01, 10, 11; idx is 2 bits and never wraps within a sweep.
REQ-020 SHALL, in DONE (one cycle), assert done=1, set pass=(result==expected) using the final result including the idx=3 sample, then return to IDLE.
REQ-021 SHALL assert done exactly 4*(SETTLE+1) cycles after the cycle in which start was accepted (SETTLE=2: 12 cycles).
REQ-022 SHALL hold result and pass stable in IDLE until the next accepted start.
REQ-023 SHALL ignore start while busy=1 or in DONE; no restart, no pulse.
REQ-024 SHALL, on abort=1 in DRIVE or SAMPLE, return to IDLE next edge with done=0, pass=0, result retaining partial samples; abort in IDLE/DONE has no effect.
REQ-025 SHALL give abort priority over start and over SAMPLE-to-DONE transition when simultaneous.
REQ-026 SHALL sample expected only in DONE; changes during a sweep are harmless.

Reset
REQ-027 SHALL, when rst=1 on an edge, force state IDLE, idx=0, settle counter=0, gate_a=gate_b=0, busy=0, done=0, pass=0, result=0.
REQ-028 SHALL give rst priority over abort and start, including mid-sweep; no done pulse results.

Verification
REQ-029 SHALL verify: SETTLE=2, AND gate attached, expected=4'b1000, start pulse -> done after 12 cycles, result=4'b1000, pass=1.
REQ-030 SHALL verify: OR gate attached, expected=4'b1000 -> result=4'b1110, pass=0, done single-cycle.
REQ-031 SHALL verify: start re-pulsed at cycle 5 of a sweep -> ignored, done still at cycle 12, exactly one done pulse.
REQ-032 SHALL verify: rst at cycle 7 of a sweep -> next edge all outputs 0, state IDLE, no done; a new start then sweeps normally.
REQ-033 SHALL verify: abort in SAMPLE of idx=3 -> IDLE, done=0, pass=0, result bits 0..3 hold samples taken.
REQ-034 SHALL verify: SETTLE=1 -> gate_a/gate_b sequence 00,00,01,01,10,10,11,11 on consecutive cycles, done after 8 cycles.
